// File: rtl/pad_pkg.sv
// Shared types and constants for the Genesis 6-button pad scanner.
package pad_pkg;

  localparam int BTN_WIDTH = 11;
  localparam int PIN_WIDTH = 6;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_START = 5;
  localparam int BTN_Z     = 6;
  localparam int BTN_Y     = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_B     = 9;
  localparam int BTN_C     = 10;

  // Synchronized pin vector layout: {start_c, a_b, right, left_x, down_y, up_z}
  localparam int PIN_UP_Z    = 0;
  localparam int PIN_DOWN_Y  = 1;
  localparam int PIN_LEFT_X  = 2;
  localparam int PIN_RIGHT   = 3;
  localparam int PIN_A_B     = 4;
  localparam int PIN_START_C = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL0_SETTLE,
    ST_SEL0_SAMPLE,
    ST_SEL1_SETTLE,
    ST_SEL1_SAMPLE,
    ST_COMPARE
  } pad_state_t;

  // With select high the right pin carries nothing useful, so it is dropped.
  function automatic logic [4:0] sel1_bits(input logic [PIN_WIDTH-1:0] pins);
    return {pins[PIN_START_C], pins[PIN_A_B], pins[PIN_LEFT_X],
            pins[PIN_DOWN_Y], pins[PIN_UP_Z]};
  endfunction

endpackage

// File: rtl/genesis_pad_scanner_if.sv
// Pad pins and committed button outputs of the Genesis pad scanner.
interface genesis_pad_scanner_if;
  import pad_pkg::*;

  logic                 up_z;
  logic                 down_y;
  logic                 left_x;
  logic                 right;
  logic                 a_b;
  logic                 start_c;
  logic                 select_out;
  logic [BTN_WIDTH-1:0] buttons;
  logic [BTN_WIDTH-1:0] pressed;
  logic                 buttons_update;
  logic                 scan_done;

  modport master (
    output up_z, down_y, left_x, right, a_b, start_c,
    input  select_out, buttons, pressed, buttons_update, scan_done
  );

  modport slave (
    input  up_z, down_y, left_x, right, a_b, start_c,
    output select_out, buttons, pressed, buttons_update, scan_done
  );

endinterface

// File: rtl/pad_sync.sv
// Two-flop synchronizer for asynchronous pad pins.
module pad_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/genesis_pad_scanner.sv
// Periodic two-phase scanner for a Genesis 6-button pad; a button state is
// committed only when two consecutive scans agree.
module genesis_pad_scanner
  import pad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SCAN_DIV      = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  genesis_pad_scanner_if.slave  pad
);

  logic [PIN_WIDTH-1:0] pins_async;
  logic [PIN_WIDTH-1:0] pins_sync;

  pad_state_t state;
  pad_state_t next_state;

  logic [15:0]          period_cnt;
  logic                 tick;
  logic [7:0]           settle_cnt;
  logic                 settle_done;
  logic                 pending;

  logic                 start_scan;
  logic                 settling;
  logic                 cap_sel0;
  logic                 cap_sel1;
  logic                 do_compare;
  logic                 select_next;
  logic                 select_q;

  logic [BTN_WIDTH-1:0] raw;
  logic [BTN_WIDTH-1:0] candidate;
  logic [BTN_WIDTH-1:0] buttons_q;
  logic [BTN_WIDTH-1:0] pressed_q;
  logic                 update_q;
  logic                 done_q;

  assign pins_async = {pad.start_c, pad.a_b, pad.right,
                       pad.left_x, pad.down_y, pad.up_z};

  pad_sync #(.WIDTH(PIN_WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pins_async),
    .q     (pins_sync)
  );

  assign tick        = (period_cnt == 16'(SCAN_DIV - 1));
  assign settle_done = (settle_cnt == 8'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) period_cnt <= '0;
    else if (tick) period_cnt <= '0;
    else period_cnt <= period_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:        if (tick || pending) next_state = ST_SEL0_SETTLE;
      ST_SEL0_SETTLE: if (settle_done) next_state = ST_SEL0_SAMPLE;
      ST_SEL0_SAMPLE: next_state = ST_SEL1_SETTLE;
      ST_SEL1_SETTLE: if (settle_done) next_state = ST_SEL1_SAMPLE;
      ST_SEL1_SAMPLE: next_state = ST_COMPARE;
      ST_COMPARE:     next_state = ST_IDLE;
      default:        next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    start_scan = 1'b0;
    settling   = 1'b0;
    cap_sel0   = 1'b0;
    cap_sel1   = 1'b0;
    do_compare = 1'b0;
    case (state)
      ST_IDLE:        start_scan = tick || pending;
      ST_SEL0_SETTLE: settling   = 1'b1;
      ST_SEL0_SAMPLE: cap_sel0   = 1'b1;
      ST_SEL1_SETTLE: settling   = 1'b1;
      ST_SEL1_SAMPLE: cap_sel1   = 1'b1;
      ST_COMPARE:     do_compare = 1'b1;
      default:        ;
    endcase
    // Registered from next_state so the pad pin never sees decode glitches.
    select_next = !((next_state == ST_SEL0_SETTLE) || (next_state == ST_SEL0_SAMPLE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) select_q <= 1'b1;
    else select_q <= select_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) settle_cnt <= '0;
    else if (settling && !settle_done) settle_cnt <= settle_cnt + 8'd1;
    else settle_cnt <= '0;
  end

  // Ticks seen mid-scan collapse into one pending request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= 1'b0;
    else if (start_scan) pending <= 1'b0;
    else if (tick && (state != ST_IDLE)) pending <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw       <= '0;
      candidate <= '0;
      buttons_q <= '0;
      pressed_q <= '0;
      update_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pressed_q <= '0;
      update_q  <= 1'b0;
      done_q    <= 1'b0;
      if (cap_sel0) raw[BTN_START:BTN_UP] <= pins_sync;
      if (cap_sel1) raw[BTN_C:BTN_Z] <= sel1_bits(pins_sync);
      if (do_compare) begin
        done_q    <= 1'b1;
        candidate <= raw;
        if (raw == candidate) begin
          buttons_q <= raw;
          pressed_q <= raw & ~buttons_q;
          update_q  <= (raw != buttons_q);
        end
      end
    end
  end

  assign pad.select_out     = select_q;
  assign pad.buttons        = buttons_q;
  assign pad.pressed        = pressed_q;
  assign pad.buttons_update = update_q;
  assign pad.scan_done      = done_q;

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// Directed bench for genesis_pad_scanner: per-scan pin patterns with
// hand-computed committed state, plus reset/timing/back-to-back sequences.
module tb_genesis_pad_scanner;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] p0;  // pins presented while select is low
  logic [5:0] p1;  // pins presented while select is high

  always #5 clk = ~clk;

  genesis_pad_scanner_if pif ();
  genesis_pad_scanner_if pif2 ();

  // Pad model: pin layout {start_c, a_b, right, left_x, down_y, up_z}
  always_comb begin
    pif.up_z    = pif.select_out ? p1[0] : p0[0];
    pif.down_y  = pif.select_out ? p1[1] : p0[1];
    pif.left_x  = pif.select_out ? p1[2] : p0[2];
    pif.right   = pif.select_out ? p1[3] : p0[3];
    pif.a_b     = pif.select_out ? p1[4] : p0[4];
    pif.start_c = pif.select_out ? p1[5] : p0[5];
  end

  assign pif2.up_z    = 1'b0;
  assign pif2.down_y  = 1'b0;
  assign pif2.left_x  = 1'b0;
  assign pif2.right   = 1'b0;
  assign pif2.a_b     = 1'b0;
  assign pif2.start_c = 1'b0;

  genesis_pad_scanner #(.SETTLE_CYCLES(4), .SCAN_DIV(32)) dut (
    .clk   (clk),
    .reset (reset),
    .pad   (pif.slave)
  );

  genesis_pad_scanner #(.SETTLE_CYCLES(4), .SCAN_DIV(8)) dut_fast (
    .clk   (clk),
    .reset (reset),
    .pad   (pif2.slave)
  );

  typedef struct {
    string       name;
    logic [5:0]  sel0;
    logic [5:0]  sel1;
    logic [10:0] exp_buttons;
    logic [10:0] exp_pressed;
    logic        exp_update;
  } vec_t;

  vec_t vecs [16];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for the next scan_done of the main DUT, noting whether buttons moved early.
  task automatic wait_done(output logic found, output logic stable);
    logic [10:0] b0;
    b0     = pif.buttons;
    found  = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (pif.scan_done) begin
        found = 1'b1;
        break;
      end
      if (pif.buttons !== b0) stable = 1'b0;
    end
  endtask

  initial begin
    logic found, stable;
    int   first_sel, first_done, interval, idx;
    logic btn_nz, done_in_reset;

    vecs[0]  = '{"hold_ab_1",   6'h10, 6'h10, 11'h000, 11'h000, 1'b0};
    vecs[1]  = '{"hold_ab_2",   6'h10, 6'h10, 11'h210, 11'h210, 1'b1};
    vecs[2]  = '{"hold_ab_3",   6'h10, 6'h10, 11'h210, 11'h000, 1'b0};
    vecs[3]  = '{"glitch_up_1", 6'h11, 6'h10, 11'h210, 11'h000, 1'b0};
    vecs[4]  = '{"glitch_up_2", 6'h10, 6'h10, 11'h210, 11'h000, 1'b0};
    vecs[5]  = '{"right_sel1",  6'h10, 6'h18, 11'h210, 11'h000, 1'b0};
    vecs[6]  = '{"release_1",   6'h00, 6'h00, 11'h210, 11'h000, 1'b0};
    vecs[7]  = '{"release_2",   6'h00, 6'h00, 11'h000, 11'h000, 1'b1};
    vecs[8]  = '{"all_1",       6'h3f, 6'h3f, 11'h000, 11'h000, 1'b0};
    vecs[9]  = '{"all_2",       6'h3f, 6'h3f, 11'h7ff, 11'h7ff, 1'b1};
    vecs[10] = '{"mix_1",       6'h09, 6'h02, 11'h7ff, 11'h000, 1'b0};
    vecs[11] = '{"mix_2",       6'h09, 6'h02, 11'h089, 11'h000, 1'b1};
    vecs[12] = '{"updown_1",    6'h03, 6'h00, 11'h089, 11'h000, 1'b0};
    vecs[13] = '{"updown_2",    6'h03, 6'h00, 11'h003, 11'h002, 1'b1};
    vecs[14] = '{"up_1",        6'h01, 6'h00, 11'h003, 11'h000, 1'b0};
    vecs[15] = '{"up_2",        6'h01, 6'h00, 11'h001, 11'h000, 1'b1};

    p0 = 6'h00;
    p1 = 6'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_select", pif.select_out, 1);
    check("rst_buttons", pif.buttons, 0);
    check("rst_pressed", pif.pressed, 0);
    check("rst_update", pif.buttons_update, 0);
    check("rst_done", pif.scan_done, 0);

    // First scan timing after release, all pins idle
    reset = 1'b0;
    first_sel = -1;
    first_done = -1;
    btn_nz = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!pif.select_out && first_sel < 0) first_sel = i;
      if (pif.scan_done && first_done < 0) first_done = i;
      if (pif.buttons != 0) btn_nz = 1'b1;
    end
    check("first_select_fall", first_sel, 31);
    check("first_scan_done", first_done, 42);
    check("idle_buttons_zero", btn_nz, 0);

    // SCAN_DIV shorter than a scan: back-to-back scans with one IDLE cycle
    interval = 0;
    while (!pif2.scan_done && interval < 100) begin
      @(negedge clk);
      interval++;
    end
    check("fast_first_done", pif2.scan_done, 1);
    for (int j = 0; j < 3; j++) begin
      interval = 0;
      do begin
        @(negedge clk);
        interval++;
      end while (!pif2.scan_done && interval < 100);
      check("fast_scan_period", interval, 12);
    end

    wait_done(found, stable);
    check("sync_scan_seen", found, 1);

    for (int i = 0; i < 16; i++) begin
      p0 = vecs[i].sel0;
      p1 = vecs[i].sel1;
      wait_done(found, stable);
      check({vecs[i].name, "_seen"}, found, 1);
      check({vecs[i].name, "_hold"}, stable, 1);
      check({vecs[i].name, "_buttons"}, pif.buttons, vecs[i].exp_buttons);
      check({vecs[i].name, "_pressed"}, pif.pressed, vecs[i].exp_pressed);
      check({vecs[i].name, "_update"}, pif.buttons_update, vecs[i].exp_update);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, pif.scan_done, 0);
      check({vecs[i].name, "_pressed_pulse"}, pif.pressed, 0);
      check({vecs[i].name, "_update_pulse"}, pif.buttons_update, 0);
    end

    // Reset during SEL1_SETTLE with buttons = 11'h001
    idx = 0;
    while (pif.select_out && idx < 100) begin @(negedge clk); idx++; end
    while (!pif.select_out && idx < 100) begin @(negedge clk); idx++; end
    check("reach_sel1_settle", idx < 100, 1);
    check("pre_reset_buttons", pif.buttons, 11'h001);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_select", pif.select_out, 1);
    check("async_rst_buttons", pif.buttons, 0);
    check("async_rst_pressed", pif.pressed, 0);
    check("async_rst_update", pif.buttons_update, 0);
    done_in_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pif.scan_done) done_in_reset = 1'b1;
    end
    check("no_done_in_reset", done_in_reset, 0);
    reset = 1'b0;
    first_done = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (pif.scan_done && first_done < 0) begin
        first_done = i;
        check("post_rst_no_commit", pif.buttons, 0);
        check("post_rst_update", pif.buttons_update, 0);
      end
    end
    check("post_rst_first_done", first_done, 42);
    wait_done(found, stable);
    check("post_rst_seen", found, 1);
    check("post_rst_buttons", pif.buttons, 11'h001);
    check("post_rst_pressed", pif.pressed, 11'h001);
    check("post_rst_upd", pif.buttons_update, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/genesis_pad_scanner.md
GENESIS_PAD_SCANNER -- requirements
Module: genesis_pad_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: clock cycles the select line is held before pad pins are sampled; legal range 1..255.
REQ-002 Parameter SCAN_DIV, default 1000: clock cycles between scan-start ticks; legal range 2..65535.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 up_z, down_y, left_x, right, a_b, start_c  input  1 each  raw DB-9 pad pins, 1 = pressed, asynchronous to clk.
REQ-006 select_out  output  1  drives pad pin 7 (select).
REQ-007 buttons  output  11  committed debounced state; index 0 Up, 1 Down, 2 Left, 3 Right, 4 A, 5 Start, 6 Z, 7 Y, 8 X, 9 B, 10 C.
REQ-008 pressed  output  11  one-cycle pulse per bit on a 0->1 change of the committed buttons bit.
REQ-009 buttons_update  output  1  one-cycle pulse when committed buttons changes value.
REQ-010 scan_done  output  1  one-cycle pulse at the end of every scan, whether or not buttons changed.

Function
REQ-011 All six pad pins SHALL pass through a 2-flop synchronizer; only synchronized values are sampled.
REQ-012 Period counter SHALL count 0..SCAN_DIV-1 and wrap; the cycle at SCAN_DIV-1 is a scan tick.
REQ-013 FSM states: IDLE, SEL0_SETTLE, SEL0_SAMPLE, SEL1_SETTLE, SEL1_SAMPLE, COMPARE.
REQ-014 IDLE: select_out=1; on a tick or with pending set, go to SEL0_SETTLE, drive select_out=0, clear pending, clear settle counter.
REQ-015 SEL0_SETTLE: hold select_out=0 for exactly SETTLE_CYCLES cycles, then SEL0_SAMPLE.
REQ-016 SEL0_SAMPLE (1 cycle): capture raw[5:0] = {start_c, a_b, right, left_x, down_y, up_z}; drive select_out=1; go to SEL1_SETTLE.
REQ-017 SEL1_SETTLE: hold select_out=1 for exactly SETTLE_CYCLES cycles, then SEL1_SAMPLE.
REQ-018 SEL1_SAMPLE (1 cycle): capture raw[10:6] = {start_c, a_b, left_x, down_y, up_z}; the right pin is ignored in this phase.
REQ-019 COMPARE (1 cycle): if raw == candidate (previous scan's raw), commit buttons <= raw; always set candidate <= raw; pulse scan_done; return to IDLE.
REQ-020 On commit, pressed SHALL equal raw & ~buttons_old for one cycle, and buttons_update SHALL pulse iff raw != buttons_old; otherwise both SHALL be 0.
REQ-021 A press SHALL therefore be committed only after two consecutive agreeing scans; a single-scan glitch never reaches buttons.
REQ-022 Scan length SHALL be 2*SETTLE_CYCLES+3 cycles from leaving IDLE to returning to IDLE.
REQ-023 A tick arriving while not in IDLE SHALL set pending; multiple ticks during one scan collapse to a single pending scan.
REQ-024 A tick and a return to IDLE in the same cycle SHALL start the next scan on the following cycle, with no lost tick.
REQ-025 buttons SHALL hold its value between commits; pressed, buttons_update and scan_done are 0 outside their pulse cycles.

Reset
REQ-026 On reset assertion, immediately and asynchronously: state=IDLE, select_out=1, buttons=0, candidate=0, raw=0, pressed=0, buttons_update=0, scan_done=0, pending=0, all counters and synchronizer flops=0.
REQ-027 Reset mid-scan SHALL abandon the scan with no commit; the first tick after release starts a fresh scan.

Structure
REQ-028 Shared package pad_pkg SHALL hold the FSM state enum, BTN_WIDTH=11, and bit-index constants BTN_UP..BTN_C.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module pad_sync, parameterized in width and instantiated once for 6 bits.

Verification (SETTLE_CYCLES=4, SCAN_DIV=32)
REQ-030 Reset released with all pins 0 -> select_out=1; first select_out 1->0 at cycle 31; scan_done 11 cycles later; buttons stays 0.
REQ-031 Hold a_b=1 throughout -> no commit after scan 1; after scan 2, buttons=11'h210, pressed=11'h210 for one cycle, buttons_update one pulse.
REQ-032 Drive up_z=1 during one select-low phase only -> buttons[0] never set.
REQ-033 SCAN_DIV=8 (less than scan length 11) -> scans run back-to-back with at most one pending, with no gaps beyond one IDLE cycle.
REQ-034 Assert reset during SEL1_SETTLE with buttons=11'h001 -> all outputs go to reset values in the same cycle; no scan_done pulse.
REQ-035 Release a held button after commit -> buttons bit clears after two agreeing scans, buttons_update pulses, pressed stays 0.
